// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes the immediate on input and buffers
// {imm, tag, illegal} in a 2-entry valid/ready FIFO with one cycle of latency.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [7:0]       illegal_cnt
);

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    // in_instr[k-7] holds instr[k], so every slice below is offset by 7.
    function automatic logic [XLEN-1:0] decode_imm(input logic [24:0] ins,
                                                   input logic [2:0]  src);
        logic [XLEN-1:0] imm;
        case (src)
            3'b000:  imm = XLEN'($signed(ins[24:13]));
            3'b001:  imm = XLEN'($signed({ins[24:18], ins[4:0]}));
            3'b010:  imm = XLEN'($signed({ins[24], ins[0], ins[23:18], ins[4:1], 1'b0}));
            3'b011:  imm = XLEN'($signed({ins[24], ins[12:5], ins[13], ins[23:14], 1'b0}));
            3'b100:  imm = XLEN'($signed({ins[24:5], 12'b0}));
            3'b101:  imm = XLEN'(ins[12:8]);
            default: imm = '0;
        endcase
        return imm;
    endfunction

    logic [XLEN-1:0]  r_imm [2];
    logic [TAG_W-1:0] r_tag [2];
    logic             r_ill [2];
    logic [1:0]       r_count;
    logic             r_head;
    logic             r_tail;
    logic             r_rdy_en;
    logic [7:0]       r_ill_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_ill;
    logic [XLEN-1:0]  w_imm;

    // r_rdy_en keeps in_ready low through reset and rises at the first edge after release.
    assign in_ready    = r_rdy_en && (r_count != 2'd2) && !flush;
    assign out_valid   = (r_count != 2'd0);
    assign imm_out     = r_imm[r_head];
    assign out_tag     = r_tag[r_head];
    assign out_illegal = r_ill[r_head];
    assign illegal_cnt = r_ill_cnt;

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;
    assign w_ill  = in_immsrc[2] && in_immsrc[1];
    assign w_imm  = decode_imm(in_instr, in_immsrc);

    // FIFO storage, pointers, occupancy and saturating illegal-select counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_imm[i] <= '0;
                r_tag[i] <= '0;
                r_ill[i] <= 1'b0;
            end
            r_count   <= 2'd0;
            r_head    <= 1'b0;
            r_tail    <= 1'b0;
            r_rdy_en  <= 1'b0;
            r_ill_cnt <= 8'd0;
        end else begin
            r_rdy_en <= 1'b1;
            if (flush) begin
                r_count <= 2'd0;
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_imm[r_tail] <= w_imm;
                    r_tag[r_tail] <= in_tag;
                    r_ill[r_tail] <= w_ill;
                    r_tail        <= ~r_tail;
                end
                if (w_pop) begin
                    r_head <= ~r_head;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
                if (w_push && w_ill && (r_ill_cnt != 8'hFF)) begin
                    r_ill_cnt <= r_ill_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The parameter XLEN SHALL default to 32, be legal only at 32 or 64, and set the width of imm_out.
REQ-002 The parameter TAG_W SHALL default to 5 and set the width of the sideband tag (for example rd index) carried with each entry.
REQ-003 The port clk SHALL be an input of 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 The port rst_n SHALL be an input of 1 bit: the reset, asynchronous and active-low.
REQ-005 The port flush SHALL be an input of 1 bit: synchronous discard of all buffered entries.
REQ-006 The port in_valid SHALL be an input of 1 bit: the upstream entry is valid.
REQ-007 The port in_ready SHALL be an output of 1 bit: the block can accept an entry.
REQ-008 The port in_instr SHALL be an input of 25 bits: instruction bits [31:7], with in_instr[k-7] = instr[k].
REQ-009 The port in_immsrc SHALL be an input of 3 bits: the immediate format select.
REQ-010 The port in_tag SHALL be an input of TAG_W bits: the sideband tag, passed through unchanged.
REQ-011 The port out_valid SHALL be an output of 1 bit: the output entry is valid.
REQ-012 The port out_ready SHALL be an input of 1 bit: downstream accepts the output entry.
REQ-013 The port imm_out SHALL be an output of XLEN bits: the extended immediate.
REQ-014 The port out_tag SHALL be an output of TAG_W bits: the tag of the output entry.
REQ-015 The port out_illegal SHALL be an output of 1 bit: the output entry had an unsupported format select.
REQ-016 The port illegal_cnt SHALL be an output of 8 bits: a saturating count of illegal selects accepted.

Function
REQ-017 in_immsrc SHALL decode as follows; "s" means sign extension from instr[31] to XLEN bits.
- 000 I-type: s(instr[31:20]).
- 001 S-type: s({instr[31:25], instr[11:7]}).
- 010 B-type: s({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- 011 J-type: s({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- 100 U-type: s({instr[31:12], 12'b0}); at XLEN=64, bits 63:32 equal instr[31].
- 101 Z-type (CSR zimm): zero extension of instr[19:15].
- 110 and 111 illegal: imm=0, illegal=1.
REQ-018 Decoding SHALL happen on input, and each buffer entry SHALL store {imm, tag, illegal}.
REQ-019 The buffer SHALL be a 2-entry FIFO with a count register of 0..2 and head/tail pointers that wrap modulo 2.
REQ-020 A push SHALL occur when in_valid && in_ready, and a pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL equal (count != 2) && !flush, and SHALL be registered-equivalent: it depends on state and flush only, never combinationally on in_valid or out_ready.
REQ-022 out_valid SHALL equal (count != 0), and imm_out/out_tag/out_illegal SHALL show the head entry.
REQ-023 Latency SHALL be 1 cycle: an entry pushed at edge N is visible on the outputs after edge N.
REQ-024 No combinational path from inputs to outputs SHALL exist.
REQ-025 Simultaneous push and pop at count=1 SHALL leave count at 1 and replace the head with the new entry on the next edge.
REQ-026 Push and pop SHALL never coincide at count=0 (out_valid=0) or at count=2 (in_ready=0).
REQ-027 Full throughput of one entry per cycle SHALL be sustained whenever out_ready is held high.
REQ-028 A stall (out_valid && !out_ready) SHALL hold imm_out, out_tag and out_illegal stable.
REQ-029 When flush=1 at an edge, count and pointers SHALL be set to 0, no push SHALL occur that cycle, and illegal_cnt SHALL be unaffected.
REQ-030 illegal_cnt SHALL increment on each push with illegal=1 and saturate at 255.
REQ-031 When XLEN is not 32 or 64, elaboration SHALL fail.

Reset
REQ-032 Assertion of rst_n=0 SHALL asynchronously set count=0, pointers=0, out_valid=0, imm_out=0, out_tag=0, out_illegal=0 and illegal_cnt=0.
REQ-033 While rst_n=0, in_ready SHALL be 0.
REQ-034 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-035 Buffered contents SHALL be discarded when reset asserts mid-operation, and no stale entry SHALL appear afterwards.

Verification
REQ-036 The bench SHALL cover format decode at XLEN=32: I with instr=0xFFF00093 -> imm=0xFFFFFFFF; B with instr=0x80000063 -> imm=0xFFFFF000; U with instr=0x12345037 -> imm=0x12345000; Z with instr[19:15]=5'b11111 -> imm=0x0000001F.
REQ-037 The bench SHALL cover XLEN=64: J with instr=0x800000EF -> imm=0xFFFFFFFFFFF00000; U with instr=0x80000037 -> imm=0xFFFFFFFF80000000.
REQ-038 The bench SHALL cover backpressure: out_ready=0 while pushing 3 entries -> in_ready=0 after 2 accepted, then out_ready=1 -> entries drain in order with tags 1, 2, followed by the third.
REQ-039 The bench SHALL cover streaming: in_valid=1 and out_ready=1 for 20 cycles -> 20 entries out, one per cycle, in order, and count never reaches 2.
REQ-040 The bench SHALL cover illegal selects: 300 pushes with immsrc=3'b110 -> out_illegal=1 and imm=0 on each, and illegal_cnt=255.
REQ-041 The bench SHALL cover flush and reset: flush at count=2 -> out_valid=0 next cycle with illegal_cnt kept; rst_n pulsed low mid-stream -> all outputs immediately 0 and in_ready=0 until the first edge after release.
